mux16x1_registered: RTL and testbench

- 16-to-1 selector: picks one of 16 data lanes from a 4-bit select and delivers it on a registered output with a valid flag.
- Used wherever a single bit (or narrow lane) must be picked from a 16-entry vector, with timing isolated by an output register.
- One clock domain.
- Default configuration (WIDTH=1) is a bit-select of a 16-bit word.

---
 rtl/mux16x1_registered.sv | 38 +++
 tb/tb_mux16x1_registered.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux16x1_registered.sv
// 16-to-1 lane selector with a registered output and a one-cycle valid flag.
// Lane k of D is D[k*WIDTH +: WIDTH]; the lane chosen by S is captured into Y when en is high.
module mux16x1_registered #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [16*WIDTH-1:0]   D,
  input  logic [3:0]            S,
  output logic [WIDTH-1:0]      Y,
  output logic                  Y_valid
);

  // Unpacked lane view so an X on S yields an X lane in simulation
  // instead of silently resolving to a fixed lane.
  logic [WIDTH-1:0] lanes [16];
  logic [WIDTH-1:0] sel_data;

  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign lanes[k] = D[k*WIDTH +: WIDTH];
  end

  assign sel_data = lanes[S];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; Y simply holds when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y       <= '0;
      Y_valid <= 1'b0;
    end else begin
      Y_valid <= en;
      if (en) Y <= sel_data;
    end
  end

endmodule

// File: tb/tb_mux16x1_registered.sv
// Self-checking bench for mux16x1_registered: WIDTH=1 and WIDTH=8 instances run in lockstep
// against a shift-and-mask reference model.
module tb_mux16x1_registered;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [3:0]   S;
  logic [15:0]  d1;
  logic [127:0] d8;
  logic         y1;
  logic         v1;
  logic [7:0]   y8;
  logic         v8;

  // Reference model state
  logic         m1_y;
  logic [7:0]   m8_y;
  logic         m_v;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] PAT = 16'b1001101001101001;

  always #5 clk = ~clk;

  mux16x1_registered #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d1), .S(S), .Y(y1), .Y_valid(v1)
  );

  mux16x1_registered #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d8), .S(S), .Y(y8), .Y_valid(v8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_y1"}, {7'd0, y1}, {7'd0, m1_y});
    check({tag, "_v1"}, {7'd0, v1}, {7'd0, m_v});
    check({tag, "_y8"}, y8, m8_y);
    check({tag, "_v8"}, {7'd0, v8}, {7'd0, m_v});
  endtask

  // Drive one set of inputs, let one rising edge sample them, update the model,
  // and return 1 time unit after the edge.
  task automatic cycle(input logic e, input logic [3:0] s,
                       input logic [15:0] dv1, input logic [127:0] dv8);
    en = e; S = s; d1 = dv1; d8 = dv8;
    @(posedge clk);
    if (rst_n) begin
      if (e) begin
        m1_y = 1'((dv1 >> s) & 16'd1);
        m8_y = 8'(dv8 >> (32'(s) * 8));
        m_v  = 1'b1;
      end else begin
        m_v  = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [127:0] ramp;
    logic [3:0]   sweep_s [7];
    logic         sweep_y [7];

    sweep_s = '{4'd1, 4'd5, 4'd9, 4'd6, 4'd11, 4'd4, 4'd10};
    sweep_y = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(k * 17);

    rst_n = 1'b0; en = 1'b1; S = 4'd0; d1 = 16'hFFFF; d8 = '1;
    m1_y = 1'b0; m8_y = 8'h00; m_v = 1'b0;

    // Reset held with capture requested: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'($urandom_range(15, 0)), 16'hFFFF, '1);
      check("rst_hold_y", {7'd0, y1}, 8'h00);
      check("rst_hold_v", {7'd0, v1}, 8'h00);
      check("rst_hold_y8", y8, 8'h00);
    end

    // Release between edges; first edge captures lane 0 of PAT.
    #3 rst_n = 1'b1;
    cycle(1'b1, 4'd0, PAT, ramp);
    check("rel_y", {7'd0, y1}, 8'h01);
    check("rel_v", {7'd0, v1}, 8'h01);
    check_model("rel");

    // Directed select sweep over PAT.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, sweep_s[i], PAT, ramp);
      check($sformatf("sweep_s%0d_y", sweep_s[i]), {7'd0, y1}, {7'd0, sweep_y[i]});
      check($sformatf("sweep_s%0d_v", sweep_s[i]), {7'd0, v1}, 8'h01);
    end

    // Walking one: only lane k is set, every select tried.
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        cycle(1'b1, 4'(s), 16'(1 << k), ramp);
        check($sformatf("walk_k%0d_s%0d", k, s), {7'd0, y1}, (s == k) ? 8'h01 : 8'h00);
      end
    end

    // Enable hold: input changes while en=0 must not reach Y.
    cycle(1'b1, 4'd5, PAT, ramp);
    check("hold_cap_y", {7'd0, y1}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd4, 16'h0000, '0);
      check("hold_y", {7'd0, y1}, 8'h01);
      check("hold_v", {7'd0, v1}, 8'h00);
      check("hold_y8", y8, 8'h55);
    end
    cycle(1'b1, 4'd4, 16'h0000, ramp);
    check("hold_resume_y", {7'd0, y1}, 8'h00);
    check("hold_resume_v", {7'd0, v1}, 8'h01);
    check("hold_resume_y8", y8, 8'h44);

    // WIDTH=8 directed lanes.
    cycle(1'b1, 4'd3, PAT, ramp);
    check("w8_s3", y8, 8'h33);
    cycle(1'b1, 4'd15, PAT, ramp);
    check("w8_s15", y8, 8'hFF);
    check("w8_s15_v", {7'd0, v8}, 8'h01);

    // Async reset pulse between edges during back-to-back captures.
    cycle(1'b1, 4'd0, PAT, ramp);
    cycle(1'b1, 4'd12, PAT, ramp);
    check("pre_pulse_y", {7'd0, y1}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    m1_y = 1'b0; m8_y = 8'h00; m_v = 1'b0;
    check("pulse_y", {7'd0, y1}, 8'h00);
    check("pulse_v", {7'd0, v1}, 8'h00);
    check("pulse_y8", y8, 8'h00);
    check("pulse_v8", {7'd0, v8}, 8'h00);
    #2 rst_n = 1'b1;
    cycle(1'b1, 4'd15, PAT, ramp);
    check("post_pulse_y", {7'd0, y1}, 8'h01);
    check("post_pulse_v", {7'd0, v1}, 8'h01);
    check("post_pulse_y8", y8, 8'hFF);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(3, 0) != 0, 4'($urandom_range(15, 0)), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
